// File: rtl/image_pkg.sv
// Shared constants and types for the image memory, its sequencer and the layer-1 controller.
package image_pkg;
   localparam int NUM_PIX = 784;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int FIFO_W  = DATA_W + ADDR_W + 1;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE} seq_state_t;

   typedef struct packed {
      logic              last;
      logic [ADDR_W-1:0] index;
      logic [DATA_W-1:0] data;
   } pix_word_t;
endpackage

// File: rtl/image_stream_sequencer_if.sv
// Pixel stream valid/ready bus between the sequencer (master) and the layer-1 MAC engine (slave).
interface image_stream_sequencer_if
   import image_pkg::*;
   ();
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] pix_data;
   logic [ADDR_W-1:0] pix_index;
   logic              pix_last;

   modport master (output pix_valid, pix_data, pix_index, pix_last, input pix_ready);
   modport slave  (input pix_valid, pix_data, pix_index, pix_last, output pix_ready);
endinterface

// File: rtl/image_stream_sequencer_skid_fifo.sv
// Two-entry skid FIFO; entry e0 is always the head, so the stream outputs come straight from a register.
module stream_skid_fifo #(
   parameter int W = 49
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [1:0]   count
);
   logic [W-1:0] e0, e1;

   assign rdata = e0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e0    <= '0;
         e1    <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= wdata;
               else               e1 <= wdata;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // simultaneous push/pop: occupancy unchanged, new word lands behind the survivor
               if (count == 2'd1) e0 <= wdata;
               else begin
                  e0 <= e1;
                  e1 <= wdata;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/image_stream_sequencer.sv
// Captures a frame, clears and loads the image memory, then streams its words to layer 1.
// Optional IMG_SEQ_ONES_COUNT_EN adds a count of accepted non-zero words.
module image_stream_sequencer
   import image_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_PIX-1:0]    frame_in,
   output logic                  mem_reset,
   output logic                  mem_init,
   output logic [NUM_PIX-1:0]    mem_pixels,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rdata,
   image_stream_sequencer_if.master pix,
   output logic                  busy,
   output logic                  done
`ifdef IMG_SEQ_ONES_COUNT_EN
   ,
   output logic [ADDR_W-1:0]     ones_count
`endif
);
   seq_state_t        state;
   logic [ADDR_W-1:0] issue_cnt, addr_q, infl_idx;
   logic              infl;
   logic [1:0]        fcount;
   logic [2:0]        occ;
   logic              issue, pop;
   pix_word_t         push_word, head;
   logic [FIFO_W-1:0] head_bits;

   assign head = pix_word_t'(head_bits);
   assign pix.pix_valid = (fcount != 2'd0);
   assign pix.pix_data  = head.data;
   assign pix.pix_index = head.index;
   assign pix.pix_last  = head.last;

   assign pop = pix.pix_valid && pix.pix_ready;
   assign occ = {1'b0, fcount} + {2'b0, infl};
   // a word leaving this cycle frees its slot, which keeps the read pipe full at ready=1
   assign issue = (state == STREAM) && !abort && ((occ < 3'd2) || pop);
   assign mem_addr = issue ? issue_cnt : addr_q;

   assign push_word = '{last: (infl_idx == LAST_IDX), index: infl_idx, data: mem_rdata};

   stream_skid_fifo #(.W(FIFO_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (abort),
      .push  (infl),
      .pop   (pop),
      .wdata (push_word),
      .rdata (head_bits),
      .count (fcount)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mem_reset  <= 1'b0;
         mem_init   <= 1'b0;
         mem_pixels <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         issue_cnt  <= '0;
         addr_q     <= '0;
         infl       <= 1'b0;
         infl_idx   <= '0;
      end else begin
         mem_reset <= 1'b0;
         mem_init  <= 1'b0;
         done      <= 1'b0;
         infl      <= issue;
         if (issue) begin
            infl_idx  <= issue_cnt;
            addr_q    <= issue_cnt;
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            issue_cnt <= '0;
            addr_q    <= '0;
            infl      <= 1'b0;
            infl_idx  <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state      <= CLEAR;
                  mem_reset  <= 1'b1;
                  busy       <= 1'b1;
                  mem_pixels <= frame_in;
                  issue_cnt  <= '0;
               end
               CLEAR: begin
                  state    <= LOAD;
                  mem_init <= 1'b1;
               end
               LOAD:   state <= STREAM;
               STREAM: if (issue && issue_cnt == LAST_IDX) state <= DRAIN;
               DRAIN: if (pop && head.last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef IMG_SEQ_ONES_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    ones_count <= '0;
      else if (state == IDLE && start && !abort)    ones_count <= '0;
      else if (pop && head.data != '0)              ones_count <= ones_count + 1'b1;
   end
`endif
endmodule

// File: tb/tb_image_stream_sequencer.sv
// Randomised bench for image_stream_sequencer with a behavioural image memory and frame-based stream model.
module tb_image_stream_sequencer;
   import image_pkg::*;

   logic clk = 0, reset = 1, start = 0, abort = 0;
   logic [NUM_PIX-1:0] frame_in = '0;
   logic mem_reset, mem_init, busy, done;
   logic [NUM_PIX-1:0] mem_pixels;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_rdata;
`ifdef IMG_SEQ_ONES_COUNT_EN
   logic [ADDR_W-1:0]  ones_count;
`endif
   image_stream_sequencer_if pif ();

   image_stream_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_in(frame_in),
      .mem_reset(mem_reset), .mem_init(mem_init), .mem_pixels(mem_pixels),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pix(pif), .busy(busy), .done(done)
`ifdef IMG_SEQ_ONES_COUNT_EN
      , .ones_count(ones_count)
`endif
   );

   always #5 clk = ~clk;

   // image memory: sync clear, sync load from the pixel frame, 1-cycle registered read
   logic [DATA_W-1:0] mem [NUM_PIX];
   always @(posedge clk) begin
      if (mem_reset) for (int i = 0; i < NUM_PIX; i++) mem[i] <= '0;
      else if (mem_init) for (int i = 0; i < NUM_PIX; i++) mem[i] <= DATA_W'(mem_pixels[i]);
      else if (int'(mem_addr) < NUM_PIX) mem_rdata <= mem[mem_addr];
   end

   int vec = 0, err = 0;
   logic [DATA_W-1:0] q_data [$];
   logic [ADDR_W-1:0] q_idx [$];
   logic              q_last [$];
   int done_cyc, first_vld, hold_err, excl_err, done_cnt;
   bit stopped;
   logic [NUM_PIX-1:0] fr, fr2;

   task automatic rand_frame(output logic [NUM_PIX-1:0] f);
      for (int i = 0; i < NUM_PIX; i++) f[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic do_start(input logic [NUM_PIX-1:0] f);
      @(negedge clk);
      frame_in = f;
      start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   // Observes the stream after an accepted start; cycle c is the negedge c cycles after the start edge.
   task automatic run_stream(input int mode, input int stop_at, input int poke_at,
                             input logic [NUM_PIX-1:0] poke_frame);
      bit stall = 0;
      logic [DATA_W-1:0] pd = '0;
      logic [ADDR_W-1:0] pi = '0;
      logic pl = 0;
      q_data.delete(); q_idx.delete(); q_last.delete();
      done_cyc = -1; first_vld = -1; hold_err = 0; excl_err = 0; done_cnt = 0; stopped = 0;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         if (c == poke_at) begin start = 1; frame_in = poke_frame; end
         else if (c == poke_at + 1) start = 0;
         if (pif.pix_valid && first_vld < 0) first_vld = c;
         if (stall && (!pif.pix_valid || pif.pix_data !== pd || pif.pix_index !== pi || pif.pix_last !== pl))
            hold_err++;
         if (mem_reset && mem_init) excl_err++;
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
         case (mode)
            0:       pif.pix_ready = 1'b1;
            1:       pif.pix_ready = c[0];
            default: pif.pix_ready = ($urandom_range(0, 99) >= 30);
         endcase
         if (pif.pix_valid && pif.pix_ready) begin
            q_data.push_back(pif.pix_data);
            q_idx.push_back(pif.pix_index);
            q_last.push_back(pif.pix_last);
         end
         stall = pif.pix_valid && !pif.pix_ready;
         pd = pif.pix_data; pi = pif.pix_index; pl = pif.pix_last;
         if (stop_at >= 0 && pif.pix_valid && pif.pix_ready && pif.pix_index == ADDR_W'(stop_at)) begin
            stopped = 1;
            break;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
   endtask

   task automatic test_reset;
      #1;
      vec++;
      if ({mem_reset, mem_init, busy, done, pif.pix_valid, pif.pix_last} !== 6'b0) begin
         err++; $display("FAIL reset_ctl: got %b want 000000", {mem_reset, mem_init, busy, done, pif.pix_valid, pif.pix_last});
      end
      vec++;
      if (mem_pixels !== '0 || mem_addr !== '0 || pif.pix_data !== '0 || pif.pix_index !== '0) begin
         err++; $display("FAIL reset_bus: addr=%0h data=%0h idx=%0h want 0", mem_addr, pif.pix_data, pif.pix_index);
      end
      @(negedge clk) reset = 0;
      repeat (2) @(negedge clk);
      vec++;
      if (busy !== 1'b0 || mem_reset !== 1'b0) begin
         err++; $display("FAIL reset_release: busy=%b mem_reset=%b want 0 0", busy, mem_reset);
      end
   endtask

   task automatic test_three_pixels;
      fr = '0; fr[0] = 1; fr[5] = 1; fr[783] = 1;
      do_start(fr);
      vec++;
      if (busy !== 1'b1 || mem_reset !== 1'b1 || mem_init !== 1'b0) begin
         err++; $display("FAIL clear_state: busy=%b mem_reset=%b mem_init=%b want 1 1 0", busy, mem_reset, mem_init);
      end
      run_stream(0, -1, -1, '0);
      vec++;
      if (done_cyc != 789) begin err++; $display("FAIL start_to_done: got %0d want 789", done_cyc); end
      vec++;
      if (done_cnt != 1) begin err++; $display("FAIL done_pulse: got %0d cycles want 1", done_cnt); end
      vec++;
      if (first_vld < 5) begin err++; $display("FAIL first_valid: got cycle %0d want >=5", first_vld); end
      vec++;
      if (excl_err != 0) begin err++; $display("FAIL mem_ctl_excl: got %0d overlaps want 0", excl_err); end
      vec++;
      if (q_idx.size() != NUM_PIX) begin err++; $display("FAIL word_count: got %0d want %0d", q_idx.size(), NUM_PIX); end
      for (int i = 0; i < q_idx.size() && i < NUM_PIX; i++) begin
         vec++;
         if (q_idx[i] !== ADDR_W'(i) || q_data[i] !== DATA_W'(fr[i]) || q_last[i] !== (i == NUM_PIX - 1)) begin
            err++; $display("FAIL three_px_word%0d: got idx=%0d data=%0h last=%b want idx=%0d data=%0h last=%b",
                            i, q_idx[i], q_data[i], q_last[i], i, fr[i], (i == NUM_PIX - 1));
         end
      end
      vec++;
      if (busy !== 1'b0 || mem_pixels !== fr) begin
         err++; $display("FAIL after_pass: busy=%b pixels_match=%b want 0 1", busy, mem_pixels === fr);
      end
   endtask

   task automatic test_backpressure;
      for (int m = 1; m <= 2; m++) begin
         rand_frame(fr);
         do_start(fr);
         run_stream(m, -1, -1, '0);
         vec++;
         if (done_cyc < 0 || done_cnt != 1) begin
            err++; $display("FAIL bp%0d_done: got cycle %0d pulses %0d want one pulse", m, done_cyc, done_cnt);
         end
         vec++;
         if (hold_err != 0) begin err++; $display("FAIL bp%0d_hold: got %0d unstable stalls want 0", m, hold_err); end
         vec++;
         if (q_idx.size() != NUM_PIX) begin err++; $display("FAIL bp%0d_count: got %0d want %0d", m, q_idx.size(), NUM_PIX); end
         for (int i = 0; i < q_idx.size() && i < NUM_PIX; i++) begin
            vec++;
            if (q_idx[i] !== ADDR_W'(i) || q_data[i] !== DATA_W'(fr[i]) || q_last[i] !== (i == NUM_PIX - 1)) begin
               err++; $display("FAIL bp%0d_word%0d: got idx=%0d data=%0h last=%b want idx=%0d data=%0h",
                               m, i, q_idx[i], q_data[i], q_last[i], i, fr[i]);
            end
         end
      end
   endtask

   task automatic test_start_ignored;
      rand_frame(fr);
      rand_frame(fr2);
      fr2[0] = ~fr[0];
      do_start(fr);
      run_stream(0, -1, 300, fr2);
      vec++;
      if (mem_pixels !== fr) begin err++; $display("FAIL busy_start_pixels: got changed frame want first frame"); end
      vec++;
      if (done_cyc != 789 || done_cnt != 1) begin
         err++; $display("FAIL busy_start_done: got cycle %0d pulses %0d want 789 1", done_cyc, done_cnt);
      end
      vec++;
      if (q_idx.size() != NUM_PIX) begin err++; $display("FAIL busy_start_count: got %0d want %0d", q_idx.size(), NUM_PIX); end
      for (int i = 0; i < q_idx.size() && i < NUM_PIX; i++) begin
         vec++;
         if (q_idx[i] !== ADDR_W'(i) || q_data[i] !== DATA_W'(fr[i])) begin
            err++; $display("FAIL busy_start_word%0d: got idx=%0d data=%0h want idx=%0d data=%0h", i, q_idx[i], q_data[i], i, fr[i]);
         end
      end
   endtask

   task automatic test_abort;
      rand_frame(fr);
      do_start(fr);
      run_stream(2, 100, -1, '0);
      vec++;
      if (!stopped) begin err++; $display("FAIL abort_reach: got no index 100 want reached"); end
      abort = 1;
      @(posedge clk);
      #1 abort = 0;
      vec++;
      if (busy !== 1'b0 || pif.pix_valid !== 1'b0 || done !== 1'b0) begin
         err++; $display("FAIL abort_idle: busy=%b valid=%b done=%b want 0 0 0", busy, pif.pix_valid, done);
      end
      done_cnt = 0;
      repeat (20) begin @(negedge clk); if (done || pif.pix_valid) done_cnt++; end
      vec++;
      if (done_cnt != 0) begin err++; $display("FAIL abort_quiet: got %0d active cycles want 0", done_cnt); end
      // start and abort together while idle: abort wins
      @(negedge clk);
      start = 1; abort = 1;
      @(posedge clk);
      #1 start = 0; abort = 0;
      vec++;
      if (busy !== 1'b0 || mem_reset !== 1'b0) begin
         err++; $display("FAIL abort_vs_start: busy=%b mem_reset=%b want 0 0", busy, mem_reset);
      end
      fr = '1;
      do_start(fr);
      run_stream(0, -1, -1, '0);
      vec++;
      if (q_idx.size() != NUM_PIX || done_cnt != 1) begin
         err++; $display("FAIL restart_count: got %0d words %0d done want %0d 1", q_idx.size(), done_cnt, NUM_PIX);
      end
      for (int i = 0; i < q_idx.size() && i < NUM_PIX; i++) begin
         vec++;
         if (q_idx[i] !== ADDR_W'(i) || q_data[i] !== DATA_W'(1)) begin
            err++; $display("FAIL restart_word%0d: got idx=%0d data=%0h want idx=%0d data=1", i, q_idx[i], q_data[i], i);
         end
      end
   endtask

   task automatic test_reset_mid;
      rand_frame(fr);
      do_start(fr);
      run_stream(0, 300, -1, '0);
      reset = 1;
      #1;
      vec++;
      if ({mem_reset, mem_init, busy, done, pif.pix_valid, pif.pix_last} !== 6'b0 || mem_pixels !== '0 ||
          mem_addr !== '0 || pif.pix_data !== '0 || pif.pix_index !== '0) begin
         err++; $display("FAIL reset_mid: ctl=%b addr=%0h idx=%0h want all 0",
                         {mem_reset, mem_init, busy, done, pif.pix_valid, pif.pix_last}, mem_addr, pif.pix_index);
      end
      @(negedge clk) reset = 0;
      rand_frame(fr);
      do_start(fr);
      run_stream(2, -1, -1, '0);
      vec++;
      if (q_idx.size() != NUM_PIX || done_cnt != 1) begin
         err++; $display("FAIL post_reset_count: got %0d words %0d done want %0d 1", q_idx.size(), done_cnt, NUM_PIX);
      end
      for (int i = 0; i < q_idx.size() && i < NUM_PIX; i++) begin
         vec++;
         if (q_idx[i] !== ADDR_W'(i) || q_data[i] !== DATA_W'(fr[i])) begin
            err++; $display("FAIL post_reset_word%0d: got idx=%0d data=%0h want idx=%0d data=%0h", i, q_idx[i], q_data[i], i, fr[i]);
         end
      end
   endtask

`ifdef IMG_SEQ_ONES_COUNT_EN
   task automatic test_ones_count;
      int n = 0;
      fr = '0;
      while (n < 17) begin
         int p = $urandom_range(0, NUM_PIX - 1);
         if (!fr[p]) begin fr[p] = 1'b1; n++; end
      end
      do_start(fr);
      run_stream(2, -1, -1, '0);
      vec++;
      if (ones_count !== ADDR_W'(17)) begin err++; $display("FAIL ones_count: got %0d want 17", ones_count); end
   endtask
`endif

   initial begin
      pif.pix_ready = 0;
      repeat (3) @(posedge clk);
      test_reset;
      test_three_pixels;
      test_backpressure;
      test_start_ignored;
      test_abort;
      test_reset_mid;
`ifdef IMG_SEQ_ONES_COUNT_EN
      test_ones_count;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
